axis_requant_pack: RTL and testbench
====================================

// Module: axis_requant_pack
// PURPOSE
// - AXI-Stream stage directly downstream of the banked D read-out (m_axis_mm2s_*).
// - Requantizes each signed 32-bit accumulator: multiply by scale, round, shift, add zero point, clamp to int8.
// - Packs four int8 results per 32-bit beat for the S2MM DMA, so IBERT layers chain in int8.
// - Bypass mode forwards raw int32 results unchanged.
// PARAMETERS
// - D_W_ACC   32  accumulator width of input samples
// - MULT_W    16  unsigned scale multiplier width
// - SHIFT_W    6  right-shift amount width (0..47 legal)
// - SAT_CNT_W 16  saturation counter width
// PORTS
// - clk            in   1        clock
// - rst            in   1        synchronous, active-high reset
// - s_axis_tdata   in   D_W_ACC  signed accumulator sample
// - s_axis_tvalid  in   1        input valid
// - s_axis_tlast   in   1        last sample of matrix
// - s_axis_tready  out  1        input ready
// - m_axis_tdata   out  32       packed int8 x4, or raw int32 in bypass
// - m_axis_tkeep   out  4        valid byte lanes
// - m_axis_tvalid  out  1        output valid
// - m_axis_tlast   out  1        last beat of matrix
// - m_axis_tready  in   1        output ready
// - cfg_mult       in   MULT_W   scale multiplier (unsigned)
// - cfg_shift      in   SHIFT_W  arithmetic right shift
// - cfg_zp         in   8        signed output zero point
// - cfg_bypass     in   1        1 = pass int32 through
// - sat_clr        in   1        clears sat_count
// - sat_count      out  SAT_CNT_W  number of clamped samples; saturates at all-ones
// BEHAVIOUR
// - Reset values:
//   - all outputs 0 except s_axis_tready.
//   - s_axis_tready = 1 once the pipeline is empty.
//   - lane counter 0; pipeline valids 0; partial word discarded.
// - Stall rule:
//   - en = m_axis_tready | ~m_axis_tvalid.
//   - s_axis_tready = en.
//   - Every pipeline register advances only when en = 1.
// - Config latch:
//   - cfg_* are sampled on the first accepted beat of each packet (lane 0, after tlast or reset).
//   - Held until that packet's tlast is accepted.
//   - Mid-packet cfg changes are ignored.
// - Stage 1: prod = signed(data) * {1'b0, cfg_mult}; 49-bit signed result.
// - Stage 2, rounding:
//   - shift = 0: r = prod.
//   - shift > 0: r = (prod + (1 << (shift-1))) >>> shift, i.e. round half toward +inf.
// - Stage 3: v = r + cfg_zp.
//   - Clamp to [-128, 127].
//   - The clamp event increments sat_count (saturating).
//   - sat_clr has priority over an increment in the same cycle.
// - Packing:
//   - Sample k of a word goes to bits [8k+7:8k]; the first sample is in [7:0].
//   - The lane counter counts 0..3.
//   - A word is emitted when lane 3 is filled, or when a sample with tlast is filled.
// - Partial word on tlast:
//   - tkeep = (1 << (lanes filled)) - 1; unused bytes are 0; tlast = 1; lane counter returns to 0.
//   - tlast on lane 3: tkeep = 4'hF, tlast = 1.
// - Bypass: m_axis_tdata = the input sample, tkeep = 4'hF, one output beat per input beat, tlast forwarded, sat_count unchanged.
// - Latency (no stall): m_axis_tvalid rises 3 cycles after the accept of the sample that completes the word.
// - Throughput: 1 input sample per cycle; 1 output word per 4 samples (1 per sample in bypass).
// - Holding rules:
//   - m_axis_tdata, tkeep and tlast are held stable while tvalid=1 and tready=0.
//   - No beat is dropped or duplicated under any tready pattern.
// - Mid-operation reset: the pipeline is flushed with no output beat and the next packet starts at lane 0.
// - Empty input stream: no output.
// - tvalid never asserts spontaneously.
// STRUCTURE
// - Shared package ibert_pkg:
//   - INT8_MIN = -128, INT8_MAX = 127
//   - LANES = 4
//   - typedef int8_t; typedef acc_t for D_W_ACC.
// - Sub-module requant_lane: 3-stage mult/round/zp/clamp datapath with enable input. Outputs int8 result, sat flag and a valid/last sideband.
// - The top holds the cfg latch, lane counter and packer register, tkeep/tlast generation, the bypass mux and sat_count.
// TESTING
// - Unity scale:
//   - Stimulus: mult=1, shift=0, zp=0; samples 1,-2,3,-4 with tlast on -4; tready=1.
//   - Expected: one beat, tdata=32'hFC03FE01, tkeep=4'hF, tlast=1, sat_count=0.
// - Rounding:
//   - Stimulus: mult=3, shift=2; samples 2,1,-2,-3.
//   - Expected: results 2,1,-1,-2 (6+2>>2=2, 3+2>>2=1, -6+2>>>2=-1, -9+2>>>2=-2).
// - Saturation and partial word:
//   - Stimulus: mult=1, shift=0, zp=10; samples 200,-300 with tlast on -300.
//   - Expected: tdata=32'h0000807F, tkeep=4'h3, tlast=1, sat_count=2.
// - Backpressure:
//   - Stimulus: 64 random samples; tready toggled randomly at 50%.
//   - Expected: output matches the reference model bit-exact; no loss; data stable while stalled.
// - Bypass:
//   - Stimulus: bypass=1; samples 32'h12345678, 32'h80000000 with tlast.
//   - Expected: two beats, identical data, tkeep=4'hF, tlast on the second.
// - Reset mid-packet: rst after 2 of 4 samples -> no output beat; next 4-sample packet packs from lane 0.

Source files
------------

// File: rtl/ibert_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ibert_pkg
//  Purpose  : Shared types, int8 bounds and lane constants for the IBERT
//             requantize/pack stream stage.
//  Revision : 1.0 - initial release
// ============================================================================
package ibert_pkg;

    localparam int ACC_W    = 32;
    localparam int LANES    = 4;
    localparam int INT8_MIN = -128;
    localparam int INT8_MAX = 127;

    typedef logic signed [7:0]       int8_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    // Byte-enable mask for a word whose highest filled lane is last_lane.
    function automatic logic [LANES-1:0] keep_mask(input logic [1:0] last_lane);
        case (last_lane)
            2'd0:    keep_mask = 4'h1;
            2'd1:    keep_mask = 4'h3;
            2'd2:    keep_mask = 4'h7;
            default: keep_mask = 4'hF;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_requant_pack_requant_lane.sv
`default_nettype none
// ============================================================================
//  Module   : requant_lane
//  Purpose  : Requantization datapath: multiply by unsigned scale, round half
//             toward +inf and shift, add zero point, clamp to int8.
//             Stage 1 and stage 2 are registered here; stage 3 (zero point
//             and clamp) is combinational and is captured by the packer
//             register in the parent, which keeps the total at three
//             register stages from input accept to output beat.
//  Revision : 1.0 - initial release
// ============================================================================
module requant_lane
    import ibert_pkg::*;
#(
    parameter int D_W_ACC = 32,
    parameter int MULT_W  = 16,
    parameter int SHIFT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    input  logic               in_last,
    input  logic               in_bypass,
    input  logic [D_W_ACC-1:0] in_data,
    input  logic [MULT_W-1:0]  in_mult,
    input  logic [SHIFT_W-1:0] in_shift,
    input  logic [7:0]         in_zp,
    output logic               out_valid,
    output logic               out_last,
    output logic               out_bypass,
    output logic [D_W_ACC-1:0] out_raw,
    output logic [7:0]         out_q,
    output logic               out_sat
);

    localparam int PROD_W = D_W_ACC + MULT_W + 1;
    localparam int RND_W  = PROD_W + 1;
    localparam int V_W    = RND_W + 1;

    localparam logic signed [V_W-1:0] c_v_min = V_W'(INT8_MIN);
    localparam logic signed [V_W-1:0] c_v_max = V_W'(INT8_MAX);

    // Stage 1 registers
    logic                     r_s1_valid;
    logic                     r_s1_last;
    logic                     r_s1_bypass;
    logic [D_W_ACC-1:0]       r_s1_raw;
    logic signed [PROD_W-1:0] r_s1_prod;
    logic [SHIFT_W-1:0]       r_s1_shift;
    logic [7:0]               r_s1_zp;

    // Stage 2 registers
    logic                     r_s2_valid;
    logic                     r_s2_last;
    logic                     r_s2_bypass;
    logic [D_W_ACC-1:0]       r_s2_raw;
    logic signed [RND_W-1:0]  r_s2_rnd;
    logic [7:0]               r_s2_zp;

    // Combinational stage values
    logic signed [PROD_W-1:0] w_prod;
    logic signed [RND_W-1:0]  w_bias;
    logic signed [RND_W-1:0]  w_sum;
    logic signed [RND_W-1:0]  w_rnd;
    logic signed [V_W-1:0]    w_v;
    logic [7:0]               w_q;
    logic                     w_sat;

    // Signed sample times zero-extended scale; the 49-bit product is exact.
    assign w_prod = PROD_W'($signed(in_data)) * PROD_W'($signed({1'b0, in_mult}));

    // Stage 1 valid tracking, flushed by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (en) begin
            r_s1_valid <= in_valid;
        end
    end

    // Stage 1 payload: product plus per-sample config carried down the pipe.
    always_ff @(posedge clk) begin
        if (en) begin
            r_s1_last   <= in_last;
            r_s1_bypass <= in_bypass;
            r_s1_raw    <= in_data;
            r_s1_prod   <= w_prod;
            r_s1_shift  <= in_shift;
            r_s1_zp     <= in_zp;
        end
    end

    // Half-LSB bias before the arithmetic shift gives round half toward +inf.
    always_comb begin
        w_bias = '0;
        if (r_s1_shift != '0) begin
            w_bias = RND_W'(1) << (r_s1_shift - SHIFT_W'(1));
        end
        w_sum = RND_W'(r_s1_prod) + w_bias;
        w_rnd = w_sum >>> r_s1_shift;
    end

    // Stage 2 valid tracking, flushed by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
        end else if (en) begin
            r_s2_valid <= r_s1_valid;
        end
    end

    // Stage 2 payload: rounded value and the remaining sideband.
    always_ff @(posedge clk) begin
        if (en) begin
            r_s2_last   <= r_s1_last;
            r_s2_bypass <= r_s1_bypass;
            r_s2_raw    <= r_s1_raw;
            r_s2_rnd    <= w_rnd;
            r_s2_zp     <= r_s1_zp;
        end
    end

    // Stage 3: add zero point and clamp to the int8 range, flagging clamps.
    always_comb begin
        w_v   = V_W'(r_s2_rnd) + V_W'($signed(r_s2_zp));
        w_q   = w_v[7:0];
        w_sat = 1'b0;
        if (w_v > c_v_max) begin
            w_q   = 8'h7F;
            w_sat = 1'b1;
        end else if (w_v < c_v_min) begin
            w_q   = 8'h80;
            w_sat = 1'b1;
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_last   = r_s2_last;
    assign out_bypass = r_s2_bypass;
    assign out_raw    = r_s2_raw;
    assign out_q      = w_q;
    assign out_sat    = w_sat & ~r_s2_bypass;

endmodule
`default_nettype wire

// File: rtl/axis_requant_pack.sv
`default_nettype none
// ============================================================================
//  Module   : axis_requant_pack
//  Purpose  : AXI-Stream int32 -> int8 requantizer. Packs four int8 results
//             per 32-bit beat (partial word with reduced tkeep on tlast),
//             or forwards raw int32 samples in bypass mode. Counts clamps.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_requant_pack
    import ibert_pkg::*;
#(
    parameter int D_W_ACC   = 32,
    parameter int MULT_W    = 16,
    parameter int SHIFT_W   = 6,
    parameter int SAT_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [D_W_ACC-1:0]   s_axis_tdata,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tlast,
    output logic                 s_axis_tready,
    output logic [31:0]          m_axis_tdata,
    output logic [3:0]           m_axis_tkeep,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready,
    input  logic [MULT_W-1:0]    cfg_mult,
    input  logic [SHIFT_W-1:0]   cfg_shift,
    input  logic [7:0]           cfg_zp,
    input  logic                 cfg_bypass,
    input  logic                 sat_clr,
    output logic [SAT_CNT_W-1:0] sat_count
);

    localparam int LANE_W = $clog2(LANES);
    localparam int PACK_W = 8 * (LANES - 1);
    localparam logic [LANE_W-1:0] c_last_lane = LANE_W'(LANES - 1);

    logic                 w_en;
    logic                 w_accept;

    // Per-packet configuration latch
    logic                 r_first;
    logic [MULT_W-1:0]    r_cfg_mult;
    logic [SHIFT_W-1:0]   r_cfg_shift;
    logic [7:0]           r_cfg_zp;
    logic                 r_cfg_bypass;
    logic [MULT_W-1:0]    w_mult;
    logic [SHIFT_W-1:0]   w_shift;
    logic [7:0]           w_zp;
    logic                 w_bypass;

    // Lane outputs (stage 3, combinational)
    logic                 w_l_valid;
    logic                 w_l_last;
    logic                 w_l_bypass;
    logic [D_W_ACC-1:0]   w_l_raw;
    logic [7:0]           w_l_q;
    logic                 w_l_sat;

    // Packer and output registers
    logic [LANE_W-1:0]    r_lane;
    logic [PACK_W-1:0]    r_pack;
    logic [31:0]          w_word;
    logic                 w_flush;
    logic [31:0]          r_m_tdata;
    logic [3:0]           r_m_tkeep;
    logic                 r_m_tvalid;
    logic                 r_m_tlast;
    logic [SAT_CNT_W-1:0] r_sat_count;

    // The whole pipeline moves only when the output slot is free or draining.
    assign w_en          = m_axis_tready | ~r_m_tvalid;
    assign w_accept      = s_axis_tvalid & w_en;
    assign s_axis_tready = w_en;

    // The first beat of a packet uses the live config; later beats the latch.
    assign w_mult   = r_first ? cfg_mult   : r_cfg_mult;
    assign w_shift  = r_first ? cfg_shift  : r_cfg_shift;
    assign w_zp     = r_first ? cfg_zp     : r_cfg_zp;
    assign w_bypass = r_first ? cfg_bypass : r_cfg_bypass;

    // Capture config on the first accepted beat, hold until tlast is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_first      <= 1'b1;
            r_cfg_mult   <= '0;
            r_cfg_shift  <= '0;
            r_cfg_zp     <= '0;
            r_cfg_bypass <= 1'b0;
        end else if (w_accept) begin
            if (r_first) begin
                r_cfg_mult   <= cfg_mult;
                r_cfg_shift  <= cfg_shift;
                r_cfg_zp     <= cfg_zp;
                r_cfg_bypass <= cfg_bypass;
            end
            r_first <= s_axis_tlast;
        end
    end

    requant_lane #(
        .D_W_ACC (D_W_ACC),
        .MULT_W  (MULT_W),
        .SHIFT_W (SHIFT_W)
    ) u_lane (
        .clk        (clk),
        .rst        (rst),
        .en         (w_en),
        .in_valid   (w_accept),
        .in_last    (s_axis_tlast),
        .in_bypass  (w_bypass),
        .in_data    (s_axis_tdata),
        .in_mult    (w_mult),
        .in_shift   (w_shift),
        .in_zp      (w_zp),
        .out_valid  (w_l_valid),
        .out_last   (w_l_last),
        .out_bypass (w_l_bypass),
        .out_raw    (w_l_raw),
        .out_q      (w_l_q),
        .out_sat    (w_l_sat)
    );

    // Insert the new int8 into the partial word at the current lane.
    always_comb begin
        w_word = {8'h00, r_pack};
        w_word[{r_lane, 3'b000} +: 8] = w_l_q;
        w_flush = w_l_last | (r_lane == c_last_lane);
    end

    // Packer / output register: emit on full word, on tlast, or per beat in bypass.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane     <= '0;
            r_pack     <= '0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
        end else if (w_en) begin
            r_m_tvalid <= 1'b0;
            if (w_l_valid) begin
                if (w_l_bypass) begin
                    r_m_tdata  <= 32'(w_l_raw);
                    r_m_tkeep  <= 4'hF;
                    r_m_tlast  <= w_l_last;
                    r_m_tvalid <= 1'b1;
                end else if (w_flush) begin
                    r_m_tdata  <= w_word;
                    r_m_tkeep  <= keep_mask(r_lane);
                    r_m_tlast  <= w_l_last;
                    r_m_tvalid <= 1'b1;
                    r_pack     <= '0;
                    r_lane     <= '0;
                end else begin
                    r_pack     <= w_word[PACK_W-1:0];
                    r_lane     <= r_lane + LANE_W'(1);
                end
            end
        end
    end

    // Clamp counter: saturates at all-ones; clear wins over a same-cycle hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_count <= '0;
        end else if (sat_clr) begin
            r_sat_count <= '0;
        end else if (w_en && w_l_valid && w_l_sat && (r_sat_count != '1)) begin
            r_sat_count <= r_sat_count + SAT_CNT_W'(1);
        end
    end

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tkeep  = r_m_tkeep;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign sat_count     = r_sat_count;

endmodule
`default_nettype wire

// File: tb/tb_axis_requant_pack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_requant_pack
//  Purpose  : Self-checking bench for axis_requant_pack: directed vector
//             table plus latency, bypass, mid-packet reset and random
//             backpressure sequences.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_axis_requant_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b1;
    logic [15:0] cfg_mult;
    logic [5:0]  cfg_shift;
    logic [7:0]  cfg_zp;
    logic        cfg_bypass;
    logic        sat_clr;
    logic [15:0] sat_count;
    logic        bp_rand = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    typedef struct {
        string             name;
        logic [15:0]       mult;
        logic [5:0]        shift;
        logic [7:0]        zp;
        int                n;
        logic [3:0][31:0]  smp;
        logic [31:0]       exp_data;
        logic [3:0]        exp_keep;
        int                exp_sat;
    } vec_t;

    beat_t q_beats[$];
    beat_t held;
    logic  held_v = 1'b0;

    axis_requant_pack dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .cfg_mult      (cfg_mult),
        .cfg_shift     (cfg_shift),
        .cfg_zp        (cfg_zp),
        .cfg_bypass    (cfg_bypass),
        .sat_clr       (sat_clr),
        .sat_count     (sat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Output-side ready: always 1 except during the random backpressure phase.
    always @(posedge clk) begin
        #1;
        m_tready = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Beat collector and hold-stability check while stalled.
    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v)
                check("hold_stable", {26'd0, m_tvalid, m_tdata, m_tkeep, m_tlast}, {26'd0, 1'b1, held});
            if (m_tvalid && m_tready)
                q_beats.push_back('{m_tdata, m_tkeep, m_tlast});
            held_v = m_tvalid && !m_tready;
            held   = '{m_tdata, m_tkeep, m_tlast};
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Reference: round half toward +inf, zero point, clamp. Returns {sat, q}.
    function automatic logic [8:0] ref_q(input logic [31:0] d, input logic [15:0] m,
                                         input logic [5:0] sh, input logic [7:0] zp);
        longint p;
        p = longint'($signed(d)) * longint'(m);
        if (sh != 6'd0)
            p = (p + (longint'(1) <<< (sh - 6'd1))) >>> sh;
        p = p + longint'($signed(zp));
        if (p > 127)       ref_q = {1'b1, 8'h7F};
        else if (p < -128) ref_q = {1'b1, 8'h80};
        else               ref_q = {1'b0, p[7:0]};
    endfunction

    function automatic vec_t mk(input string nm, input int m, input int sh, input int zp, input int n,
                                input int s0, input int s1, input int s2, input int s3,
                                input logic [31:0] ed, input logic [3:0] ek, input int es);
        vec_t v;
        v.name = nm; v.mult = 16'(m); v.shift = 6'(sh); v.zp = 8'(zp); v.n = n;
        v.smp[0] = 32'(s0); v.smp[1] = 32'(s1); v.smp[2] = 32'(s2); v.smp[3] = 32'(s3);
        v.exp_data = ed; v.exp_keep = ek; v.exp_sat = es;
        return v;
    endfunction

    task automatic set_cfg(input logic [15:0] m, input logic [5:0] sh, input logic [7:0] zp, input logic byp);
        cfg_mult = m; cfg_shift = sh; cfg_zp = zp; cfg_bypass = byp;
    endtask

    task automatic pulse_clr();
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
    endtask

    // Present one sample and hold it until it is accepted (bounded).
    task automatic send(input logic [31:0] d, input logic l);
        int  n = 0;
        logic acc = 1'b0;
        s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
        while (!acc) begin
            @(negedge clk); acc = s_tready;
            @(posedge clk); #1;
            n++;
            if (!acc && n > 500) begin
                check("send_timeout", 64'd0, 64'd1);
                break;
            end
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int t = 0;
        while (q_beats.size() < n && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        if (q_beats.size() < n)
            check("beat_timeout", 64'(q_beats.size()), 64'(n));
    endtask

    initial begin : main
        vec_t  vt[8];
        beat_t b;
        beat_t exp_q[$];
        int    lat;
        int    sats;
        int    sent;
        int    p;
        int    n;
        logic [31:0] d;
        logic [31:0] word;
        logic [8:0]  r;

        vt[0] = mk("unity",        1,     0,  0, 4, 1, -2, 3, -4,                    32'hFC03FE01, 4'hF, 0);
        vt[1] = mk("rounding",     3,     2,  0, 4, 2, 1, -2, -3,                    32'hFEFF0102, 4'hF, 0);
        vt[2] = mk("half_up",      1,     1,  0, 4, 3, -3, 1, -1,                    32'h0001FF02, 4'hF, 0);
        vt[3] = mk("single_zp",    256,   8, -5, 1, 7, 0, 0, 0,                      32'h00000002, 4'h1, 0);
        vt[4] = mk("q15_three",    32768, 15, 0, 3, 100, -100, 5, 0,                 32'h00059C64, 4'h7, 0);
        vt[5] = mk("max_shift",    65535, 47, 0, 3, 32'h7FFFFFFF, 32'h80000000, 0, 0, 32'h0000FF01, 4'h7, 0);
        vt[6] = mk("sat_partial",  1,     0, 10, 2, 200, -300, 0, 0,                 32'h0000807F, 4'h3, 2);
        vt[7] = mk("clamp_bounds", 1,     0,  0, 4, 127, -128, 128, -129,            32'h807F807F, 4'hF, 2);

        rst = 1'b1; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; sat_clr = 1'b0;
        set_cfg(16'd1, 6'd0, 8'd0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tdata",  64'(m_tdata),  64'd0);
        check("rst_tkeep",  64'(m_tkeep),  64'd0);
        check("rst_tlast",  64'(m_tlast),  64'd0);
        check("rst_sat",    64'(sat_count), 64'd0);
        check("rst_sready", 64'(s_tready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vector table; config is scrambled after the first beat.
        for (int i = 0; i < 8; i++) begin
            set_cfg(vt[i].mult, vt[i].shift, vt[i].zp, 1'b0);
            pulse_clr();
            for (int k = 0; k < vt[i].n; k++) begin
                send(vt[i].smp[k], k == vt[i].n - 1);
                if (k == 0) set_cfg(16'd7, 6'd3, 8'd99, 1'b1);
            end
            wait_beats(1, 30);
            if (q_beats.size() > 0) begin
                b = q_beats.pop_front();
                check({vt[i].name, "_data"}, 64'(b.d), 64'(vt[i].exp_data));
                check({vt[i].name, "_keep"}, 64'(b.k), 64'(vt[i].exp_keep));
                check({vt[i].name, "_last"}, 64'(b.l), 64'd1);
            end
            repeat (6) @(posedge clk); #1;
            check({vt[i].name, "_extra"}, 64'(q_beats.size()), 64'd0);
            check({vt[i].name, "_sat"},   64'(sat_count), 64'(vt[i].exp_sat));
        end

        pulse_clr();
        check("sat_clr", 64'(sat_count), 64'd0);

        // Latency: accept of the completing sample to tvalid high.
        set_cfg(16'd1, 6'd0, 8'd0, 1'b0);
        send(32'd5, 1'b1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!m_tvalid && lat < 10);
        check("latency", 64'(lat), 64'd3);
        @(posedge clk); #1;
        wait_beats(1, 10);
        if (q_beats.size() > 0) begin
            b = q_beats.pop_front();
            check("lat_data", 64'(b.d), 64'h5);
            check("lat_keep", 64'(b.k), 64'h1);
        end

        // Bypass: raw int32 forwarded, one beat per sample, no clamp counting.
        set_cfg(16'd1, 6'd0, 8'd0, 1'b1);
        pulse_clr();
        send(32'h12345678, 1'b0);
        set_cfg(16'd3, 6'd1, 8'd0, 1'b0);
        send(32'h80000000, 1'b1);
        wait_beats(2, 30);
        if (q_beats.size() >= 2) begin
            b = q_beats.pop_front();
            check("byp0_data", 64'(b.d), 64'h12345678);
            check("byp0_keep", 64'(b.k), 64'hF);
            check("byp0_last", 64'(b.l), 64'd0);
            b = q_beats.pop_front();
            check("byp1_data", 64'(b.d), 64'h80000000);
            check("byp1_keep", 64'(b.k), 64'hF);
            check("byp1_last", 64'(b.l), 64'd1);
        end
        repeat (5) @(posedge clk); #1;
        check("byp_sat",   64'(sat_count), 64'd0);
        check("byp_extra", 64'(q_beats.size()), 64'd0);

        // Reset mid-packet: two samples reach the packer, then reset.
        set_cfg(16'd1, 6'd0, 8'd0, 1'b0);
        send(32'd9, 1'b0);
        send(32'd8, 1'b0);
        repeat (4) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(posedge clk); #1;
        check("rstmid_nobeat", 64'(q_beats.size()), 64'd0);
        check("rstmid_sready", 64'(s_tready), 64'd1);
        send(32'd1, 1'b0);
        send(32'hFFFFFFFE, 1'b0);
        send(32'd3, 1'b0);
        send(32'hFFFFFFFC, 1'b1);
        wait_beats(1, 30);
        if (q_beats.size() > 0) begin
            b = q_beats.pop_front();
            check("rstmid_data", 64'(b.d), 64'hFC03FE01);
            check("rstmid_keep", 64'(b.k), 64'hF);
            check("rstmid_last", 64'(b.l), 64'd1);
        end

        // Random backpressure: 64 samples, packet lengths cycling 1..4.
        set_cfg(16'd300, 6'd4, 8'hFD, 1'b0);
        pulse_clr();
        bp_rand = 1'b1;
        sats = 0; sent = 0; p = 0;
        while (sent < 64) begin
            n = (p % 4) + 1;
            if (n > 64 - sent) n = 64 - sent;
            word = '0;
            for (int k = 0; k < n; k++) begin
                d = 32'($signed($urandom) >>> $urandom_range(20, 31));
                r = ref_q(d, 16'd300, 6'd4, 8'hFD);
                sats += int'(r[8]);
                word[8*k +: 8] = r[7:0];
                send(d, k == n - 1);
            end
            exp_q.push_back('{word, 4'((5'd1 << n) - 5'd1), 1'b1});
            sent += n;
            p++;
        end
        wait_beats(exp_q.size(), 2000);
        bp_rand = 1'b0;
        check("bp_count", 64'(q_beats.size()), 64'(exp_q.size()));
        while (q_beats.size() > 0 && exp_q.size() > 0) begin
            b = q_beats.pop_front();
            check("bp_beat", 64'(b), 64'(exp_q.pop_front()));
        end
        repeat (5) @(posedge clk); #1;
        check("bp_sat", 64'(sat_count), 64'(sats));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
